// File: rtl/procyon_ifq.sv
// rtl/procyon_ifq.sv - instruction fetch queue for the icache miss path
// Deduplicated line-miss FIFO, one outstanding line read, multi-beat assembly and one-cycle fill.
module procyon_ifq #(
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_IFQ_DEPTH      = 2,
  parameter int OPTN_IC_LINE_SIZE   = 32,
  parameter int OPTN_MEM_DATA_WIDTH = 64,
  parameter int IC_LINE_WIDTH       = OPTN_IC_LINE_SIZE * 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           i_ifq_alloc_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_ifq_alloc_addr,
  output logic                           o_ifq_full,
  output logic                           o_ifq_fill_en,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_ifq_fill_addr,
  output logic [IC_LINE_WIDTH-1:0]       o_ifq_fill_data,
  output logic                           o_mem_req_en,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_mem_req_addr,
  input  logic                           i_mem_req_ack,
  input  logic                           i_mem_rsp_valid,
  input  logic [OPTN_MEM_DATA_WIDTH-1:0] i_mem_rsp_data
);

  localparam int BEATS  = IC_LINE_WIDTH / OPTN_MEM_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (OPTN_IFQ_DEPTH > 1) ? $clog2(OPTN_IFQ_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OPTN_IFQ_DEPTH + 1);

  localparam logic [BEAT_W-1:0]          LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]           LAST_PTR  = PTR_W'(OPTN_IFQ_DEPTH - 1);
  localparam logic [CNT_W-1:0]           DEPTH_CNT = CNT_W'(OPTN_IFQ_DEPTH);
  localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK = ~(OPTN_ADDR_WIDTH'(OPTN_IC_LINE_SIZE - 1));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_BEATS = 2'd2;
  localparam logic [1:0] S_FILL  = 2'd3;

  logic [OPTN_ADDR_WIDTH-1:0] entry_addr [OPTN_IFQ_DEPTH];
  logic [OPTN_IFQ_DEPTH-1:0]  entry_valid;
  logic [PTR_W-1:0]           head;
  logic [PTR_W-1:0]           tail;
  logic [CNT_W-1:0]           count;
  logic [1:0]                 state;
  logic [BEAT_W-1:0]          beat_cnt;
  logic [IC_LINE_WIDTH-1:0]   line_q;

  logic [OPTN_ADDR_WIDTH-1:0] alloc_line;
  logic                       alloc_match;
  logic                       alloc_ok;
  logic                       pop;
  logic                       beat_fire;

  assign alloc_line = i_ifq_alloc_addr & LINE_MASK;
  assign pop        = (state == S_FILL);
  assign beat_fire  = (state == S_BEATS) && i_mem_rsp_valid;
  assign alloc_ok   = i_ifq_alloc_en && !o_ifq_full && !alloc_match;

  // Dedup looks at every valid entry, including the head currently being served.
  always_comb begin
    alloc_match = 1'b0;
    for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == alloc_line)) begin
        alloc_match = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      entry_valid <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= (head == LAST_PTR) ? '0 : head + 1'b1;
      end
      if (alloc_ok) begin
        entry_valid[tail] <= 1'b1;
        tail              <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      if (alloc_ok && !pop) begin
        count <= count + 1'b1;
      end else if (!alloc_ok && pop) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      entry_addr[tail] <= alloc_line;
    end
    if (beat_fire) begin
      line_q[beat_cnt*OPTN_MEM_DATA_WIDTH +: OPTN_MEM_DATA_WIDTH] <= i_mem_rsp_data;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_req_ack) begin
            state    <= S_BEATS;
            beat_cnt <= '0;
          end
        end
        S_BEATS: begin
          if (i_mem_rsp_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state <= S_FILL;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, and are zeroed outside their active state.
  assign o_ifq_full      = (count == DEPTH_CNT);
  assign o_mem_req_en    = (state == S_REQ);
  assign o_mem_req_addr  = o_mem_req_en ? entry_addr[head] : '0;
  assign o_ifq_fill_en   = pop;
  assign o_ifq_fill_addr = pop ? entry_addr[head] : '0;
  assign o_ifq_fill_data = pop ? line_q : '0;

endmodule

// File: tb/tb_procyon_ifq.sv
// tb/tb_procyon_ifq.sv - directed self-checking bench for procyon_ifq
// Default parameters: 32-byte line, 64-bit beats (4 beats), depth 2.
module tb_procyon_ifq;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         i_ifq_alloc_en = 1'b0;
  logic [31:0]  i_ifq_alloc_addr = '0;
  logic         o_ifq_full;
  logic         o_ifq_fill_en;
  logic [31:0]  o_ifq_fill_addr;
  logic [255:0] o_ifq_fill_data;
  logic         o_mem_req_en;
  logic [31:0]  o_mem_req_addr;
  logic         i_mem_req_ack = 1'b0;
  logic         i_mem_rsp_valid = 1'b0;
  logic [63:0]  i_mem_rsp_data = '0;

  int errors = 0;
  int checks = 0;

  procyon_ifq dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .i_ifq_alloc_en   (i_ifq_alloc_en),
    .i_ifq_alloc_addr (i_ifq_alloc_addr),
    .o_ifq_full       (o_ifq_full),
    .o_ifq_fill_en    (o_ifq_fill_en),
    .o_ifq_fill_addr  (o_ifq_fill_addr),
    .o_ifq_fill_data  (o_ifq_fill_data),
    .o_mem_req_en     (o_mem_req_en),
    .o_mem_req_addr   (o_mem_req_addr),
    .i_mem_req_ack    (i_mem_req_ack),
    .i_mem_rsp_valid  (i_mem_rsp_valid),
    .i_mem_rsp_data   (i_mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input logic [7:0] b0, input int k);
    logic [7:0] b;
    b = b0 * 8'(k + 1);
    return {8{b}};
  endfunction

  function automatic logic [255:0] line_val(input logic [7:0] b0);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = beat_val(b0, k);
    return l;
  endfunction

  // Wait for the request, ack it, feed four beats, return in the fill cycle after checking it.
  task automatic serve(input string tag, input logic [31:0] line, input logic [7:0] b0, input bit gaps);
    for (int i = 0; i < 8 && !o_mem_req_en; i++) tick();
    check({tag, "_req_en"}, 256'(o_mem_req_en), 256'(1));
    check({tag, "_req_addr"}, 256'(o_mem_req_addr), 256'(line));
    if (gaps) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = 64'hdead_beef_dead_beef;
      tick();
      i_mem_rsp_valid = 1'b0;
    end
    i_mem_req_ack = 1'b1;
    tick();
    i_mem_req_ack = 1'b0;
    check({tag, "_req_drop"}, 256'(o_mem_req_en), 256'(0));
    for (int k = 0; k < 4; k++) begin
      if (gaps && (k % 2 == 1)) begin
        i_mem_rsp_valid = 1'b0;
        tick();
      end
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = beat_val(b0, k);
      check({tag, "_no_early_fill"}, 256'(o_ifq_fill_en), 256'(0));
      tick();
    end
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    check({tag, "_fill_en"}, 256'(o_ifq_fill_en), 256'(1));
    check({tag, "_fill_addr"}, 256'(o_ifq_fill_addr), 256'(line));
    check({tag, "_fill_data"}, o_ifq_fill_data, line_val(b0));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_no_req"}, 256'(o_mem_req_en), 256'(0));
      check({tag, "_no_fill"}, 256'(o_ifq_fill_en), 256'(0));
      tick();
    end
  endtask

  task automatic alloc(input logic [31:0] a);
    i_ifq_alloc_en   = 1'b1;
    i_ifq_alloc_addr = a;
  endtask

  task automatic alloc_off();
    i_ifq_alloc_en   = 1'b0;
    i_ifq_alloc_addr = '0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_full", 256'(o_ifq_full), 256'(0));
    check("rst_req_en", 256'(o_mem_req_en), 256'(0));
    check("rst_req_addr", 256'(o_mem_req_addr), 256'(0));
    check("rst_fill_en", 256'(o_ifq_fill_en), 256'(0));
    check("rst_fill_addr", 256'(o_ifq_fill_addr), 256'(0));
    check("rst_fill_data", o_ifq_fill_data, 256'(0));
    n_rst = 1'b0;
    tick();

    // Single miss with exact cycle timing
    alloc(32'h1004);
    check("t1_c0_req", 256'(o_mem_req_en), 256'(0));
    tick();
    alloc_off();
    check("t1_c1_req", 256'(o_mem_req_en), 256'(0));
    tick();
    check("t1_c2_req", 256'(o_mem_req_en), 256'(1));
    check("t1_c2_addr", 256'(o_mem_req_addr), 256'(32'h1000));
    tick();
    check("t1_c3_req", 256'(o_mem_req_en), 256'(1));
    tick();
    check("t1_c4_req", 256'(o_mem_req_en), 256'(1));
    i_mem_req_ack = 1'b1;
    tick();
    i_mem_req_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_req_off", 256'(o_mem_req_en), 256'(0));
      check("t1_no_fill", 256'(o_ifq_fill_en), 256'(0));
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = beat_val(8'h11, k);
      tick();
    end
    i_mem_rsp_valid = 1'b0;
    check("t1_c9_fill_en", 256'(o_ifq_fill_en), 256'(1));
    check("t1_c9_fill_addr", 256'(o_ifq_fill_addr), 256'(32'h1000));
    check("t1_c9_fill_data", o_ifq_fill_data,
          {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111});
    tick();
    check("t1_c10_fill_en", 256'(o_ifq_fill_en), 256'(0));
    check("t1_c10_fill_data", o_ifq_fill_data, 256'(0));
    expect_quiet("t1_after", 4);

    // Dedup
    alloc(32'h2008);
    tick();
    alloc(32'h2010);
    tick();
    alloc_off();
    check("t2_not_full", 256'(o_ifq_full), 256'(0));
    serve("t2", 32'h2000, 8'h21, 1'b0);
    tick();
    expect_quiet("t2_after", 6);

    // Full/drop plus ordering with bubbles and stray beats
    alloc(32'h100);
    check("t3_c0_full", 256'(o_ifq_full), 256'(0));
    tick();
    alloc(32'h200);
    check("t3_c1_full", 256'(o_ifq_full), 256'(0));
    tick();
    alloc(32'h300);
    check("t3_c2_full", 256'(o_ifq_full), 256'(1));
    tick();
    alloc_off();
    check("t3_c3_full", 256'(o_ifq_full), 256'(1));
    serve("t3a", 32'h100, 8'h05, 1'b1);
    check("t3_fill_full", 256'(o_ifq_full), 256'(1));
    tick();
    check("t3_pop_full", 256'(o_ifq_full), 256'(0));
    check("t3_idle_req", 256'(o_mem_req_en), 256'(0));
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = 64'hbad0_bad0_bad0_bad0;
    tick();
    i_mem_rsp_valid = 1'b0;
    check("t3_next_req_now", 256'(o_mem_req_en), 256'(1));
    serve("t3b", 32'h200, 8'h07, 1'b1);
    tick();
    expect_quiet("t3_no_300", 6);

    // Simultaneous alloc and pop
    alloc(32'h300);
    tick();
    alloc_off();
    serve("t5a", 32'h300, 8'h31, 1'b0);
    alloc(32'h400);
    tick();
    alloc_off();
    check("t5_full_after", 256'(o_ifq_full), 256'(0));
    check("t5_idle_req", 256'(o_mem_req_en), 256'(0));
    tick();
    check("t5_req_2later", 256'(o_mem_req_en), 256'(1));
    serve("t5b", 32'h400, 8'h41, 1'b0);
    tick();
    check("t5_empty_full", 256'(o_ifq_full), 256'(0));
    expect_quiet("t5_after", 4);

    // Reset in BEATS
    alloc(32'h500);
    tick();
    alloc(32'h600);
    tick();
    alloc_off();
    check("t6_full", 256'(o_ifq_full), 256'(1));
    check("t6_req", 256'(o_mem_req_en), 256'(1));
    check("t6_req_addr", 256'(o_mem_req_addr), 256'(32'h500));
    i_mem_req_ack = 1'b1;
    tick();
    i_mem_req_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = beat_val(8'h51, k);
      tick();
    end
    i_mem_rsp_data = beat_val(8'h51, 2);
    n_rst = 1'b1;
    #1;
    check("t6_rst_full", 256'(o_ifq_full), 256'(0));
    check("t6_rst_req", 256'(o_mem_req_en), 256'(0));
    check("t6_rst_req_addr", 256'(o_mem_req_addr), 256'(0));
    check("t6_rst_fill", 256'(o_ifq_fill_en), 256'(0));
    check("t6_rst_fill_addr", 256'(o_ifq_fill_addr), 256'(0));
    check("t6_rst_fill_data", o_ifq_fill_data, 256'(0));
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    for (int k = 2; k < 4; k++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = beat_val(8'h51, k);
      check("t6_late_fill", 256'(o_ifq_fill_en), 256'(0));
      tick();
    end
    i_mem_rsp_valid = 1'b0;
    check("t6_post_full", 256'(o_ifq_full), 256'(0));
    expect_quiet("t6_after", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
